// File: rtl/lag_test_sequencer.sv
// Display-lag test sequencer: shows a patch, waits for the photo-sensor edge, then a dark gap.
// Define LAG_TIMEOUT_EN to abandon a test after TIMEOUT_FRAMES frames without a sensor edge.
module lag_test_sequencer #(
    parameter int DARK_FRAMES    = 4,
    parameter int TIMEOUT_FRAMES = 60
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_frame_start,
    input  logic       i_config_change,
    input  logic       i_sensor_in,
    output logic       o_patch_on,
    output logic       o_measure_reset,
    output logic       o_sensor_trigger,
    output logic       o_bcd_clear,
    output logic [7:0] o_test_count,
    output logic [7:0] o_timeout_count,
    output logic       o_busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DARK = 2'd3;

    localparam logic [7:0] DARK_LAST = 8'(DARK_FRAMES - 1);
`ifdef LAG_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_FRAMES - 1);
`endif

    logic [1:0] r_state;
    logic [7:0] r_frame_cnt;
    logic       r_sync1, r_sync2, r_sync3;
    logic [1:0] r_settle;
    logic       r_patch_on, r_measure_reset, r_sensor_trigger, r_bcd_clear, r_busy;
    logic [7:0] r_test_count, r_timeout_count;
    logic       w_raw_edge;

    // The edge detector is held off until r_sync3 holds a real post-reset sample,
    // so a sensor already high at reset release is not mistaken for an edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_sync1 <= i_sensor_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    assign w_raw_edge = r_sync2 & ~r_sync3 & (r_settle == 2'd3);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_frame_cnt      <= 8'd0;
            r_patch_on       <= 1'b0;
            r_measure_reset  <= 1'b0;
            r_sensor_trigger <= 1'b0;
            r_bcd_clear      <= 1'b0;
            r_busy           <= 1'b0;
            r_test_count     <= 8'd0;
            r_timeout_count  <= 8'd0;
        end else begin
            r_measure_reset  <= 1'b0;
            r_sensor_trigger <= 1'b0;
            r_bcd_clear      <= 1'b0;
            r_busy           <= (r_state != S_IDLE);
            // Configuration change outranks everything, including a coincident sensor edge.
            if (i_config_change) begin
                r_bcd_clear     <= 1'b1;
                r_test_count    <= 8'd0;
                r_timeout_count <= 8'd0;
                r_patch_on      <= 1'b0;
                r_frame_cnt     <= 8'd0;
                r_state         <= S_IDLE;
            end else if (!i_enable) begin
                r_patch_on  <= 1'b0;
                r_frame_cnt <= 8'd0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_frame_cnt <= 8'd0;
                        r_state     <= S_ARM;
                    end
                    S_ARM: begin
                        if (i_frame_start) begin
                            r_patch_on      <= 1'b1;
                            r_measure_reset <= 1'b1;
                            r_frame_cnt     <= 8'd0;
                            r_state         <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_raw_edge) begin
                            r_sensor_trigger <= 1'b1;
                            r_test_count     <= (r_test_count == 8'hFF) ? 8'hFF : r_test_count + 8'd1;
                            r_patch_on       <= 1'b0;
                            r_frame_cnt      <= 8'd0;
                            r_state          <= S_DARK;
`ifdef LAG_TIMEOUT_EN
                        end else if (i_frame_start && (r_frame_cnt == TIMEOUT_LAST)) begin
                            r_timeout_count <= (r_timeout_count == 8'hFF) ? 8'hFF : r_timeout_count + 8'd1;
                            r_patch_on      <= 1'b0;
                            r_frame_cnt     <= 8'd0;
                            r_state         <= S_DARK;
`endif
                        end else if (i_frame_start && (r_frame_cnt != 8'hFF)) begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                    default: begin
                        if (i_frame_start) begin
                            if (r_frame_cnt == DARK_LAST) begin
                                r_frame_cnt <= 8'd0;
                                r_state     <= S_ARM;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign o_patch_on       = r_patch_on;
    assign o_measure_reset  = r_measure_reset;
    assign o_sensor_trigger = r_sensor_trigger;
    assign o_bcd_clear      = r_bcd_clear;
    assign o_test_count     = r_test_count;
    assign o_timeout_count  = r_timeout_count;
    assign o_busy           = r_busy;
endmodule

// File: tb/tb_lag_test_sequencer.sv
// Scoreboard bench for lag_test_sequencer: scripted test episodes push expected events,
// a negedge monitor pops and compares them as the DUT pulses its outputs.
`timescale 1ns/1ps
module tb_lag_test_sequencer;
    localparam int DARK = 4;
    localparam int TMO  = 3;
    localparam int K_MR = 0, K_TRIG = 1, K_CLR = 2, K_TO = 3;
    localparam int P_BUSY = 0, P_PATCH = 1, P_TCNT = 2, P_TOCNT = 3;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, frame_start = 1'b0;
    logic config_change = 1'b0, sensor_in = 1'b0;
    logic patch_on, measure_reset, sensor_trigger, bcd_clear, busy;
    logic [7:0] test_count, timeout_count;

    typedef struct {int kind; int cyc; int tcnt; int tocnt; int plen;} ev_t;
    typedef struct {int cyc; int sig; int val;} probe_t;
    ev_t    ev_q[$];
    probe_t pr_q[$];
    probe_t mon_p;

    int cyc = 0;
    int n_checks = 0, n_errors = 0;
    int m_tests = 0, m_timeouts = 0;
    int run = 0, last_run = 0;
    logic [7:0] prev_to = 8'd0;
    bit done = 1'b0;

    lag_test_sequencer #(.DARK_FRAMES(DARK), .TIMEOUT_FRAMES(TMO)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_frame_start(frame_start),
        .i_config_change(config_change), .i_sensor_in(sensor_in),
        .o_patch_on(patch_on), .o_measure_reset(measure_reset), .o_sensor_trigger(sensor_trigger),
        .o_bcd_clear(bcd_clear), .o_test_count(test_count), .o_timeout_count(timeout_count),
        .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_MR:    return "measure_reset";
            K_TRIG:  return "sensor_trigger";
            K_CLR:   return "bcd_clear";
            default: return "timeout";
        endcase
    endfunction

    function automatic string pname(input int s);
        case (s)
            P_BUSY:  return "busy";
            P_PATCH: return "patch_on";
            P_TCNT:  return "test_count";
            default: return "timeout_count";
        endcase
    endfunction

    function automatic int get_sig(input int s);
        case (s)
            P_BUSY:  return int'(busy);
            P_PATCH: return int'(patch_on);
            P_TCNT:  return int'(test_count);
            default: return int'(timeout_count);
        endcase
    endfunction

    // ---------------- stimulus side ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic expect_ev(input int kind, input int at, input int plen);
        ev_t e;
        e.kind = kind; e.cyc = at; e.tcnt = m_tests; e.tocnt = m_timeouts; e.plen = plen;
        ev_q.push_back(e);
    endtask

    task automatic probe(input int at, input int sig, input int val);
        probe_t p;
        p.cyc = at; p.sig = sig; p.val = val;
        pr_q.push_back(p);
    endtask

    // Frame_start while armed: measure_reset and patch_on appear one cycle later.
    task automatic start_test(output int f);
        f = cyc;
        expect_ev(K_MR, f + 1, -1);
        frame();
    endtask

    // Sensor rise: trigger three cycles later; patch stayed on since the measure_reset cycle.
    task automatic sense(input int f);
        int t;
        t = cyc + 3;
        m_tests = sat(m_tests + 1);
        expect_ev(K_TRIG, t, t - f - 1);
        sensor_in = 1'b1;
        tick(4);
        sensor_in = 1'b0;
    endtask

    // DARK frames of darkness, then the sequencer is armed again; sensor noise must be ignored.
    task automatic dark_phase(input int gmin, input int gmax, input bit noise);
        for (int i = 0; i < DARK; i++) begin
            tick($urandom_range(gmin, gmax));
            if (noise && ($urandom_range(0, 1) == 1)) begin
                sensor_in = 1'b1;
                tick(3);
                sensor_in = 1'b0;
            end
            frame();
        end
        if (noise) begin
            sensor_in = 1'b1;
            tick(3);
            sensor_in = 1'b0;
        end
        tick(4);
    endtask

    task automatic sensed_test(input int lag, input int gmin, input int gmax, input bit noise);
        int f;
        start_test(f);
        tick(lag);
        sense(f);
        dark_phase(gmin, gmax, noise);
    endtask

    initial begin
        int f, s, c, e;
        tick(3);
        rst = 1'b0;
        tick(2);
        enable = 1'b1;
        c = cyc;
        probe(c + 1, P_BUSY, 0);
        probe(c + 2, P_BUSY, 1);
        tick(3);

        // Sensor 40 cycles after measure_reset, frames roughly every 100 cycles.
        sensed_test(40, 99, 99, 1'b0);
        for (int i = 0; i < 8; i++)
            sensed_test($urandom_range(1, 60), 2, 10, 1'b1);

`ifdef LAG_TIMEOUT_EN
        // Timeout: first waiting frame lands in the measure_reset cycle.
        start_test(f);
        for (int i = 0; i < TMO; i++) begin
            if (i == TMO - 1) begin
                m_timeouts = sat(m_timeouts + 1);
                expect_ev(K_TO, cyc + 1, cyc - f);
            end
            frame();
            if (i != TMO - 1) tick(2);
        end
        dark_phase(2, 5, 1'b0);
        // Sensor edge coincident with the timeout frame: the edge wins.
        start_test(f);
        for (int i = 0; i < TMO - 1; i++) begin
            frame();
            tick(2);
        end
        s = cyc;
        m_tests = sat(m_tests + 1);
        expect_ev(K_TRIG, s + 3, s + 2 - f);
        sensor_in = 1'b1;
        tick(2);
        frame();
        tick(2);
        sensor_in = 1'b0;
        dark_phase(2, 5, 1'b0);
`else
        // No timeout build: 300 frames of waiting change nothing.
        start_test(f);
        repeat (300) begin
            frame();
            tick(1);
        end
        probe(cyc, P_BUSY, 1);
        probe(cyc, P_PATCH, 1);
        probe(cyc, P_TOCNT, 0);
        tick(1);
        sense(f);
        dark_phase(2, 5, 1'b0);
`endif

        // config_change coincident with the raw sensor edge.
        start_test(f);
        tick(5);
        sensor_in = 1'b1;
        s = cyc;
        tick(2);
        config_change = 1'b1;
        m_tests = 0;
        m_timeouts = 0;
        expect_ev(K_CLR, s + 3, -1);
        probe(s + 3, P_BUSY, 1);
        probe(s + 4, P_BUSY, 0);
        probe(s + 5, P_BUSY, 1);
        tick(1);
        config_change = 1'b0;
        tick(3);
        sensor_in = 1'b0;
        tick(4);

        // config_change coincident with frame_start while armed: no measure_reset.
        frame_start = 1'b1;
        config_change = 1'b1;
        expect_ev(K_CLR, cyc + 1, -1);
        tick(1);
        frame_start = 1'b0;
        config_change = 1'b0;
        tick(3);
        sensed_test($urandom_range(1, 30), 2, 6, 1'b1);

        // enable low mid-test: patch drops, no pulses, counters kept.
        start_test(f);
        tick(3);
        probe(cyc, P_PATCH, 1);
        enable = 1'b0;
        e = cyc;
        probe(e + 1, P_PATCH, 0);
        probe(e + 2, P_BUSY, 0);
        probe(e + 2, P_TCNT, m_tests);
        tick(2);
        sensor_in = 1'b1;
        tick(6);
        sensor_in = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(3);
        sensed_test($urandom_range(1, 30), 2, 6, 1'b0);

        // Asynchronous reset mid-test with the sensor high across release.
        start_test(f);
        tick(3);
        probe(cyc, P_PATCH, 1);
        tick(1);
        rst = 1'b1;
        m_tests = 0;
        m_timeouts = 0;
        tick(2);
        sensor_in = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        start_test(f);
        tick(10);
        sensor_in = 1'b0;
        tick(4);
        sense(f);
        dark_phase(2, 5, 1'b0);

        // Saturation of test_count.
        repeat (300)
            sensed_test($urandom_range(1, 6), 1, 3, ($urandom_range(0, 1) == 1));
        probe(cyc + 1, P_TCNT, 255);
        tick(5);
        done = 1'b1;
        tick(10);
    end

    // ---------------- checking side ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic handle(input int kind);
        ev_t e;
        $display("cycle %0d: %s test_count=%0d timeout_count=%0d", cyc, kname(kind), test_count, timeout_count);
        if (ev_q.size() == 0 || ev_q[0].cyc > cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", kname(kind), cyc);
            return;
        end
        e = ev_q.pop_front();
        check("event_kind", kind, e.kind);
        check("test_count", int'(test_count), e.tcnt);
        check("timeout_count", int'(timeout_count), e.tocnt);
        check("patch_on_at_event", int'(patch_on), (kind == K_MR) ? 1 : 0);
        if (e.plen >= 0) check("patch_on_length", last_run, e.plen);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("reset_patch_on", int'(patch_on), 0);
            check("reset_measure_reset", int'(measure_reset), 0);
            check("reset_sensor_trigger", int'(sensor_trigger), 0);
            check("reset_bcd_clear", int'(bcd_clear), 0);
            check("reset_busy", int'(busy), 0);
            check("reset_test_count", int'(test_count), 0);
            check("reset_timeout_count", int'(timeout_count), 0);
            prev_to = 8'd0;
            run = 0;
        end else begin
            if (patch_on) run++;
            else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_%s: got nothing by cycle %0d, expected at cycle %0d",
                         kname(ev_q[0].kind), cyc, ev_q[0].cyc);
                void'(ev_q.pop_front());
            end
            if (bcd_clear) handle(K_CLR);
            if (measure_reset) handle(K_MR);
            if (sensor_trigger) handle(K_TRIG);
            if (timeout_count != prev_to && !bcd_clear) handle(K_TO);
            prev_to = timeout_count;
            while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
                mon_p = pr_q.pop_front();
                if (mon_p.cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL probe_missed_%s: got no sample at cycle %0d, expected %0d",
                             pname(mon_p.sig), mon_p.cyc, mon_p.val);
                end else begin
                    check(pname(mon_p.sig), get_sig(mon_p.sig), mon_p.val);
                end
            end
        end
        if (done || cyc > 90000) begin
            if (!done) begin
                n_checks++;
                n_errors++;
                $display("FAIL watchdog: got cycle %0d, expected end of stimulus", cyc);
            end
            check("leftover_events", ev_q.size(), 0);
            check("leftover_probes", pr_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end
endmodule
